// File: rtl/nn_pipe_ctrl.sv
// nn_pipe_ctrl: pipeline controller for the 3-stage (IF / ID / EX-WB) NN processor.
// Owns the PC, the fetch handshake, the IF/ID register, EX valid tracking,
// RAW forwarding selects, load-use stalls, HALT detection and perf counters.
module nn_pipe_ctrl #(
  parameter int unsigned         BUS_WIDTH = 32,
  parameter int unsigned         PC_WIDTH  = 16,
  parameter int unsigned         REGISTER  = 6,
  parameter int unsigned         OPCODE    = 4,
  parameter logic [OPCODE-1:0]   HALT_OP   = 4'hF,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_data,
  output logic [BUS_WIDTH-1:0] instr_d,
  output logic                 instr_d_valid,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic [REGISTER-1:0]  id_dst,
  output logic                 idex_load,
  output logic                 idex_bubble,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic                 fwd_c,
  output logic                 stall,
  output logic                 ex_valid,
  output logic                 halted,
  output logic [BUS_WIDTH-1:0] cycle_cnt,
  output logic [BUS_WIDTH-1:0] retired_cnt,
  output logic [BUS_WIDTH-1:0] stall_cnt
);

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
  localparam logic [BUS_WIDTH-1:0] CNT_ONE = BUS_WIDTH'(1);

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [BUS_WIDTH-1:0] ifid_q, ifid_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic                 ex_valid_q, ex_valid_d;
  logic                 ex_reg_write_q, ex_reg_write_d;
  logic                 ex_is_load_q, ex_is_load_d;
  logic [REGISTER-1:0]  ex_dst_q, ex_dst_d;
  logic                 halted_q, halted_d;
  logic [BUS_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [BUS_WIDTH-1:0] retired_cnt_q, retired_cnt_d;
  logic [BUS_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic [REGISTER-1:0]  src_a, src_b, src_c;
  logic [OPCODE-1:0]    opcode;
  logic                 hit_a, hit_b, hit_c;
  logic                 stall_w, issue, halt_take, req_w, fetch;

  // Hazard detection on the instruction sitting in ID against the one in EX
  always_comb begin
    src_a     = ifid_q[27 -: REGISTER];
    src_b     = ifid_q[21 -: REGISTER];
    src_c     = ifid_q[15 -: REGISTER];
    opcode    = ifid_q[BUS_WIDTH-1 -: OPCODE];
    hit_a     = ifid_valid_q & ex_valid_q & ex_reg_write_q & (src_a == ex_dst_q);
    hit_b     = ifid_valid_q & ex_valid_q & ex_reg_write_q & (src_b == ex_dst_q);
    hit_c     = ifid_valid_q & ex_valid_q & ex_reg_write_q & (src_c == ex_dst_q);
    stall_w   = (hit_a | hit_b | hit_c) & ex_is_load_q;
    issue     = ifid_valid_q & ~stall_w;
    halt_take = issue & (opcode == HALT_OP);
    req_w     = ~halted_q & ~stall_w;
    fetch     = req_w & imem_ack;
  end

  // Next-state for PC, IF/ID, EX tracking, HALT flag and counters
  always_comb begin
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    if (fetch) begin
      pc_d = pc_q + PC_ONE;
      // the word returned alongside an issuing HALT is dropped, but its address is consumed
      if (halt_take) begin
        ifid_valid_d = 1'b0;
      end else begin
        ifid_d       = imem_data;
        ifid_valid_d = 1'b1;
      end
    end else if (!stall_w) begin
      ifid_valid_d = 1'b0;
    end

    ex_valid_d     = issue & ~halted_q;
    ex_reg_write_d = ex_valid_d & id_reg_write;
    ex_is_load_d   = ex_valid_d & id_is_load;
    ex_dst_d       = id_dst;

    halted_d       = halted_q | halt_take;

    cycle_cnt_d    = halted_q   ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
    retired_cnt_d  = ex_valid_q ? retired_cnt_q + CNT_ONE : retired_cnt_q;
    stall_cnt_d    = stall_w    ? stall_cnt_q + CNT_ONE : stall_cnt_q;
  end

  // Fetch state: program counter and IF/ID instruction register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q         <= RESET_PC;
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // EX-stage shadow of the decoded controls, bubbles carry no write enables
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_dst_q       <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_dst_q       <= ex_dst_d;
    end
  end

  // Sticky HALT flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Performance counters, free-wrapping
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign imem_req      = req_w;
  assign imem_addr     = pc_q;
  assign instr_d       = ifid_q;
  assign instr_d_valid = ifid_valid_q;
  assign idex_load     = issue;
  assign idex_bubble   = ~issue;
  assign fwd_a         = hit_a & ~ex_is_load_q;
  assign fwd_b         = hit_b & ~ex_is_load_q;
  assign fwd_c         = hit_c & ~ex_is_load_q;
  assign stall         = stall_w;
  assign ex_valid      = ex_valid_q;
  assign halted        = halted_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign retired_cnt   = retired_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule
